// File: rtl/btb_upd_ctrl_if.sv
// Update-request and predictor-write signals of the BTB update controller.
// Each request port is a valid/ready pair: a transfer happens on a clock edge where both are high.
interface btb_upd_ctrl_if;
   logic        ex_upd_valid;
   logic        ex_upd_op;
   logic [31:0] ex_upd_pc;
   logic [31:0] ex_upd_target;
   logic        ex_upd_ready;

   logic        id_upd_valid;
   logic        id_upd_op;
   logic [31:0] id_upd_pc;
   logic [31:0] id_upd_target;
   logic        id_upd_ready;

   logic        btb_wr_valid;
   logic [1:0]  btb_wr_op;
   logic [31:0] btb_wr_pc;
   logic [31:0] btb_wr_target;
   logic [5:0]  btb_wr_set;

   modport master (
      output ex_upd_valid, ex_upd_op, ex_upd_pc, ex_upd_target,
      input  ex_upd_ready,
      output id_upd_valid, id_upd_op, id_upd_pc, id_upd_target,
      input  id_upd_ready,
      input  btb_wr_valid, btb_wr_op, btb_wr_pc, btb_wr_target, btb_wr_set
   );

   modport slave (
      input  ex_upd_valid, ex_upd_op, ex_upd_pc, ex_upd_target,
      output ex_upd_ready,
      input  id_upd_valid, id_upd_op, id_upd_pc, id_upd_target,
      output id_upd_ready,
      output btb_wr_valid, btb_wr_op, btb_wr_pc, btb_wr_target, btb_wr_set
   );
endinterface

// File: rtl/btb_upd_ctrl.sv
// BTB update controller: merges EXU/IDU updates through an age-ordered queue
// with INVAL-over-ALLOC squashing, and sweeps every predictor set on flush.
module btb_upd_ctrl #(
   parameter int DEPTH    = 4,
   parameter int NUM_SETS = 64
) (
   input  logic          clk,
   input  logic          rst,
   btb_upd_ctrl_if.slave upd,
   input  logic          flush_req,
   output logic          flush_busy,
   output logic          flush_done,
   output logic [1:0]    dbg_state
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [5:0] LAST_SET = 6'(NUM_SETS - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, SWEEP = 2'd2} state_t;

   state_t            state_q, state_n;
   logic [PW-1:0]     head_q, tail_q, id_slot;
   logic [CW-1:0]     count_q, vcount, count_n;
   logic [5:0]        sweep_q;
   logic [DEPTH-1:0]  live_q, live_n;
   logic              op_q  [DEPTH];
   logic [31:0]       pc_q  [DEPTH];
   logic [31:0]       tgt_q [DEPTH];

   logic              ex_acc, id_acc, pop, sweep_issue;
   logic              h_op;
   logic [31:0]       h_pc, h_tgt;

   assign upd.ex_upd_ready = (state_q != SWEEP) && (count_q < CW'(DEPTH));
   assign upd.id_upd_ready = (state_q != SWEEP) &&
                             ((32'(count_q) + 32'(upd.ex_upd_valid)) < 32'(DEPTH));

   assign ex_acc      = upd.ex_upd_valid && upd.ex_upd_ready;
   assign id_acc      = upd.id_upd_valid && upd.id_upd_ready;
   assign id_slot     = tail_q + PW'(ex_acc);
   assign vcount      = count_q + CW'(ex_acc) + CW'(id_acc);
   assign pop         = (vcount != '0) && (state_q != SWEEP) && !flush_req;
   assign sweep_issue = (state_q == SWEEP) && !flush_req;
   assign count_n     = vcount - CW'(pop);

   // Live bits after this cycle's enqueues and squashes; the head is popped from
   // this view so a request into an empty queue issues on the very next edge.
   always_comb begin
      live_n = live_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (ex_acc && upd.ex_upd_op && !op_q[i] && (pc_q[i] == upd.ex_upd_pc))
            live_n[i] = 1'b0;
         if (id_acc && upd.id_upd_op && !op_q[i] && (pc_q[i] == upd.id_upd_pc))
            live_n[i] = 1'b0;
      end
      if (ex_acc)
         live_n[tail_q] = !(id_acc && upd.id_upd_op && !upd.ex_upd_op &&
                            (upd.id_upd_pc == upd.ex_upd_pc));
      if (id_acc)
         live_n[id_slot] = !(ex_acc && upd.ex_upd_op && !upd.id_upd_op &&
                             (upd.ex_upd_pc == upd.id_upd_pc));
   end

   always_comb begin
      h_op  = op_q[head_q];
      h_pc  = pc_q[head_q];
      h_tgt = tgt_q[head_q];
      if (count_q == '0) begin
         h_op  = ex_acc ? upd.ex_upd_op     : upd.id_upd_op;
         h_pc  = ex_acc ? upd.ex_upd_pc     : upd.id_upd_pc;
         h_tgt = ex_acc ? upd.ex_upd_target : upd.id_upd_target;
      end
   end

   always_comb begin
      state_n = state_q;
      if (flush_req)
         state_n = SWEEP;
      else if (state_q == SWEEP)
         state_n = (sweep_q == LAST_SET) ? IDLE : SWEEP;
      else
         state_n = (count_n != '0) ? DRAIN : IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         sweep_q <= '0;
         live_q  <= '0;
      end else begin
         state_q <= state_n;
         if (flush_req) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            sweep_q <= '0;
            live_q  <= '0;
         end else begin
            head_q  <= head_q + PW'(pop);
            tail_q  <= tail_q + PW'(ex_acc) + PW'(id_acc);
            count_q <= count_n;
            live_q  <= live_n;
            if (sweep_issue)
               sweep_q <= sweep_q + 6'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (ex_acc) begin
         op_q[tail_q]  <= upd.ex_upd_op;
         pc_q[tail_q]  <= upd.ex_upd_pc;
         tgt_q[tail_q] <= upd.ex_upd_target;
      end
      if (id_acc) begin
         op_q[id_slot]  <= upd.id_upd_op;
         pc_q[id_slot]  <= upd.id_upd_pc;
         tgt_q[id_slot] <= upd.id_upd_target;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         upd.btb_wr_valid  <= 1'b0;
         upd.btb_wr_op     <= 2'b00;
         upd.btb_wr_pc     <= '0;
         upd.btb_wr_target <= '0;
         upd.btb_wr_set    <= '0;
         flush_done        <= 1'b0;
      end else begin
         flush_done <= sweep_issue && (sweep_q == LAST_SET);
         if (sweep_issue) begin
            upd.btb_wr_valid  <= 1'b1;
            upd.btb_wr_op     <= 2'b10;
            upd.btb_wr_pc     <= '0;
            upd.btb_wr_target <= '0;
            upd.btb_wr_set    <= sweep_q;
         end else if (pop && live_n[head_q]) begin
            upd.btb_wr_valid  <= 1'b1;
            upd.btb_wr_op     <= {1'b0, h_op};
            upd.btb_wr_pc     <= h_pc;
            upd.btb_wr_target <= h_tgt;
            upd.btb_wr_set    <= h_pc[7:2];
         end else begin
            upd.btb_wr_valid  <= 1'b0;
            upd.btb_wr_op     <= 2'b00;
            upd.btb_wr_pc     <= '0;
            upd.btb_wr_target <= '0;
            upd.btb_wr_set    <= '0;
         end
      end
   end

   assign flush_busy = (state_q == SWEEP);
   assign dbg_state  = state_q;
endmodule

// File: tb/tb_btb_upd_ctrl.sv
// Directed bench for btb_upd_ctrl: latency, ordering, squash, flush sweep and reset.
module tb_btb_upd_ctrl;
   logic       clk, rst, flush_req, flush_busy, flush_done;
   logic [1:0] dbg_state;
   int         n_vec, n_err;
   logic [31:0] exp_q[$];

   btb_upd_ctrl_if u_if();

   btb_upd_ctrl #(.DEPTH(4), .NUM_SETS(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .upd        (u_if),
      .flush_req  (flush_req),
      .flush_busy (flush_busy),
      .flush_done (flush_done),
      .dbg_state  (dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ex(input logic v, input logic op, input logic [31:0] pc, input logic [31:0] tgt);
      u_if.ex_upd_valid  = v;
      u_if.ex_upd_op     = op;
      u_if.ex_upd_pc     = pc;
      u_if.ex_upd_target = tgt;
   endtask

   task automatic drive_id(input logic v, input logic op, input logic [31:0] pc, input logic [31:0] tgt);
      u_if.id_upd_valid  = v;
      u_if.id_upd_op     = op;
      u_if.id_upd_pc     = pc;
      u_if.id_upd_target = tgt;
   endtask

   task automatic idle_inputs();
      drive_ex(1'b0, 1'b0, 32'h0, 32'h0);
      drive_id(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      flush_req = 1'b0;
      idle_inputs();
      #2 rst = 1'b0;
      #10;
      n_vec++;
      if (u_if.btb_wr_valid !== 1'b0) begin
         n_err++; $display("FAIL rst_wr_valid got %b exp 0", u_if.btb_wr_valid);
      end
      n_vec++;
      if ({u_if.btb_wr_op, u_if.btb_wr_pc, u_if.btb_wr_target, u_if.btb_wr_set} !== 72'h0) begin
         n_err++; $display("FAIL rst_wr_fields got op %b pc %h tgt %h set %h exp all 0",
                           u_if.btb_wr_op, u_if.btb_wr_pc, u_if.btb_wr_target, u_if.btb_wr_set);
      end
      n_vec++;
      if ({flush_busy, flush_done} !== 2'b00) begin
         n_err++; $display("FAIL rst_flush got %b exp 00", {flush_busy, flush_done});
      end
      n_vec++;
      if ({u_if.ex_upd_ready, u_if.id_upd_ready} !== 2'b11) begin
         n_err++; $display("FAIL rst_ready got %b exp 11", {u_if.ex_upd_ready, u_if.id_upd_ready});
      end
      n_vec++;
      if (dbg_state !== 2'd0) begin
         n_err++; $display("FAIL rst_state got %0d exp 0", dbg_state);
      end
      #10 rst = 1'b1;
      cyc();
      @(negedge clk);
      n_vec++;
      if ({u_if.btb_wr_valid, u_if.btb_wr_set, flush_busy, flush_done, u_if.ex_upd_ready, u_if.id_upd_ready} !== 11'b00000000011) begin
         n_err++; $display("FAIL post_rst_outputs got v %b set %h busy %b done %b rdy %b%b exp v0 set0 busy0 done0 rdy11",
                           u_if.btb_wr_valid, u_if.btb_wr_set, flush_busy, flush_done, u_if.ex_upd_ready, u_if.id_upd_ready);
      end
      cyc();
   endtask

   task automatic test_single_alloc();
      drive_ex(1'b1, 1'b0, 32'h1C00_0010, 32'h1C00_0100);
      @(negedge clk);
      n_vec++;
      if (u_if.ex_upd_ready !== 1'b1) begin
         n_err++; $display("FAIL single_ready got %b exp 1", u_if.ex_upd_ready);
      end
      cyc();
      idle_inputs();
      @(negedge clk);
      n_vec++;
      if ({u_if.btb_wr_valid, u_if.btb_wr_op, u_if.btb_wr_set, u_if.btb_wr_target, u_if.btb_wr_pc} !==
          {1'b1, 2'b00, 6'h04, 32'h1C00_0100, 32'h1C00_0010}) begin
         n_err++; $display("FAIL single_write got v %b op %b set %h tgt %h pc %h exp v1 op00 set04 tgt 1c000100 pc 1c000010",
                           u_if.btb_wr_valid, u_if.btb_wr_op, u_if.btb_wr_set, u_if.btb_wr_target, u_if.btb_wr_pc);
      end
      cyc();
      @(negedge clk);
      n_vec++;
      if (u_if.btb_wr_valid !== 1'b0) begin
         n_err++; $display("FAIL single_after got %b exp 0", u_if.btb_wr_valid);
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp;
      exp_q.delete();
      for (int k = 0; k < 8; k++) begin
         if (k < 3) begin
            drive_ex(1'b1, 1'b0, 32'h1C00_1000 + 32'(k * 16), 32'h1C00_5000);
            drive_id(1'b1, 1'b0, 32'h1C00_2000 + 32'(k * 16), 32'h1C00_6000);
            exp_q.push_back(32'h1C00_1000 + 32'(k * 16));
            exp_q.push_back(32'h1C00_2000 + 32'(k * 16));
         end else if (k == 3) begin
            drive_ex(1'b1, 1'b0, 32'h1C00_1030, 32'h1C00_5000);
            drive_id(1'b1, 1'b0, 32'h1C00_2030, 32'h1C00_6000);
            exp_q.push_back(32'h1C00_1030);
         end else begin
            idle_inputs();
         end
         @(negedge clk);
         if (k < 3) begin
            n_vec++;
            if ({u_if.ex_upd_ready, u_if.id_upd_ready} !== 2'b11) begin
               n_err++; $display("FAIL b2b_ready cycle %0d got %b exp 11", k, {u_if.ex_upd_ready, u_if.id_upd_ready});
            end
         end else if (k == 3) begin
            n_vec++;
            if ({u_if.ex_upd_ready, u_if.id_upd_ready} !== 2'b10) begin
               n_err++; $display("FAIL b2b_count_plus_one got %b exp 10", {u_if.ex_upd_ready, u_if.id_upd_ready});
            end
         end
         if (k >= 1) begin
            exp = exp_q.pop_front();
            n_vec++;
            if (u_if.btb_wr_valid !== 1'b1 || u_if.btb_wr_pc !== exp) begin
               n_err++; $display("FAIL b2b_order cycle %0d got v %b pc %h exp v1 pc %h", k, u_if.btb_wr_valid, u_if.btb_wr_pc, exp);
            end
         end
         cyc();
      end
      @(negedge clk);
      n_vec++;
      if (u_if.btb_wr_valid !== 1'b0) begin
         n_err++; $display("FAIL b2b_drained got %b exp 0", u_if.btb_wr_valid);
      end
      cyc();
   endtask

   task automatic test_squash();
      bit          ev [11] = '{0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 0};
      logic [1:0]  eop[11] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
      logic [31:0] epc[11] = '{32'h0, 32'h1C00_0444, 32'h1C00_0548, 32'h1C00_064C, 32'h0, 32'h1C00_0020,
                               32'h0, 32'h0, 32'h1C00_0080, 32'h0, 32'h0};
      logic [5:0]  eset[11] = '{6'h00, 6'h11, 6'h12, 6'h13, 6'h00, 6'h08, 6'h00, 6'h00, 6'h20, 6'h00, 6'h00};
      for (int k = 0; k < 11; k++) begin
         idle_inputs();
         case (k)
            0: begin
               drive_ex(1'b1, 1'b0, 32'h1C00_0444, 32'h1C00_7000);
               drive_id(1'b1, 1'b0, 32'h1C00_0548, 32'h1C00_7100);
            end
            1: begin
               drive_ex(1'b1, 1'b0, 32'h1C00_064C, 32'h1C00_7200);
               drive_id(1'b1, 1'b0, 32'h1C00_0020, 32'h1C00_0900);
            end
            2: drive_ex(1'b1, 1'b1, 32'h1C00_0020, 32'h0);
            7: begin
               drive_ex(1'b1, 1'b1, 32'h1C00_0080, 32'h0);
               drive_id(1'b1, 1'b0, 32'h1C00_0080, 32'h1C00_0A00);
            end
            default: ;
         endcase
         @(negedge clk);
         if (k >= 1) begin
            n_vec++;
            if (ev[k]) begin
               if ({u_if.btb_wr_valid, u_if.btb_wr_op, u_if.btb_wr_pc, u_if.btb_wr_set} !== {1'b1, eop[k], epc[k], eset[k]}) begin
                  n_err++; $display("FAIL squash_write cycle %0d got v %b op %b pc %h set %h exp v1 op %b pc %h set %h",
                                    k, u_if.btb_wr_valid, u_if.btb_wr_op, u_if.btb_wr_pc, u_if.btb_wr_set, eop[k], epc[k], eset[k]);
               end
            end else if (u_if.btb_wr_valid !== 1'b0) begin
               n_err++; $display("FAIL squash_hole cycle %0d got v %b exp 0", k, u_if.btb_wr_valid);
            end
         end
         cyc();
      end
   endtask

   task automatic test_flush();
      logic [31:0] exp;
      exp_q.delete();
      for (int k = 0; k < 4; k++) begin
         idle_inputs();
         if (k < 3) begin
            drive_ex(1'b1, 1'b0, 32'h1C00_0104 + 32'(k * 16), 32'h1C00_8000);
            drive_id(1'b1, 1'b0, 32'h1C00_0208 + 32'(k * 16), 32'h1C00_8100);
            exp_q.push_back(32'h1C00_0104 + 32'(k * 16));
            exp_q.push_back(32'h1C00_0208 + 32'(k * 16));
         end else begin
            flush_req = 1'b1;
         end
         @(negedge clk);
         if (k >= 1) begin
            exp = exp_q.pop_front();
            n_vec++;
            if (u_if.btb_wr_valid !== 1'b1 || u_if.btb_wr_pc !== exp) begin
               n_err++; $display("FAIL flush_prefill cycle %0d got v %b pc %h exp v1 pc %h", k, u_if.btb_wr_valid, u_if.btb_wr_pc, exp);
            end
         end
         cyc();
      end
      flush_req = 1'b0;
      drive_ex(1'b1, 1'b0, 32'h1C00_0030, 32'h1C00_0330);
      @(negedge clk);
      n_vec++;
      if ({u_if.btb_wr_valid, flush_busy, u_if.ex_upd_ready, u_if.id_upd_ready} !== 4'b0100) begin
         n_err++; $display("FAIL flush_start got v %b busy %b rdy %b%b exp v0 busy1 rdy00",
                           u_if.btb_wr_valid, flush_busy, u_if.ex_upd_ready, u_if.id_upd_ready);
      end
      for (int j = 0; j < 64; j++) begin
         cyc();
         @(negedge clk);
         n_vec++;
         if ({u_if.btb_wr_valid, u_if.btb_wr_op, u_if.btb_wr_set, u_if.btb_wr_pc, u_if.btb_wr_target} !==
             {1'b1, 2'b10, 6'(j), 32'h0, 32'h0}) begin
            n_err++; $display("FAIL sweep_write step %0d got v %b op %b set %h pc %h exp v1 op10 set %h pc 0",
                              j, u_if.btb_wr_valid, u_if.btb_wr_op, u_if.btb_wr_set, u_if.btb_wr_pc, 6'(j));
         end
         n_vec++;
         if ({flush_busy, flush_done, u_if.ex_upd_ready} !== ((j == 63) ? 3'b011 : 3'b100)) begin
            n_err++; $display("FAIL sweep_status step %0d got busy %b done %b rdy %b exp %b",
                              j, flush_busy, flush_done, u_if.ex_upd_ready, (j == 63) ? 3'b011 : 3'b100);
         end
      end
      cyc();
      idle_inputs();
      @(negedge clk);
      n_vec++;
      if ({u_if.btb_wr_valid, u_if.btb_wr_op, u_if.btb_wr_pc, u_if.btb_wr_set} !== {1'b1, 2'b00, 32'h1C00_0030, 6'h0C}) begin
         n_err++; $display("FAIL held_req_after_sweep got v %b op %b pc %h set %h exp v1 op00 pc 1c000030 set 0c",
                           u_if.btb_wr_valid, u_if.btb_wr_op, u_if.btb_wr_pc, u_if.btb_wr_set);
      end
      cyc();
      @(negedge clk);
      n_vec++;
      if ({u_if.btb_wr_valid, flush_done} !== 2'b00) begin
         n_err++; $display("FAIL flush_quiet got v %b done %b exp 00", u_if.btb_wr_valid, flush_done);
      end
      cyc();
   endtask

   task automatic test_flush_restart();
      int n_clr = 0;
      int n_done = 0;
      int exp_set = 0;
      bit seq_ok = 1'b1;
      bit restarted = 1'b0;
      bit trig = 1'b0;
      flush_req = 1'b1;
      cyc();
      flush_req = 1'b0;
      for (int c = 0; c < 200 && n_done == 0; c++) begin
         if (trig && !restarted) begin
            flush_req = 1'b1;
            restarted = 1'b1;
         end else begin
            flush_req = 1'b0;
         end
         @(negedge clk);
         if (u_if.btb_wr_valid === 1'b1 && u_if.btb_wr_op === 2'b10) begin
            if (u_if.btb_wr_set !== 6'(exp_set)) seq_ok = 1'b0;
            n_clr++;
            exp_set++;
            if (!restarted && u_if.btb_wr_set === 6'd18) trig = 1'b1;
         end
         if (flush_done === 1'b1) n_done++;
         if (flush_req) exp_set = 0;
         cyc();
      end
      flush_req = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (u_if.btb_wr_valid === 1'b1) n_clr++;
         if (flush_done === 1'b1) n_done++;
         cyc();
      end
      n_vec++;
      if (n_clr != 84) begin
         n_err++; $display("FAIL restart_clrset_count got %0d exp 84", n_clr);
      end
      n_vec++;
      if (n_done != 1) begin
         n_err++; $display("FAIL restart_done_count got %0d exp 1", n_done);
      end
      n_vec++;
      if (!(seq_ok && restarted)) begin
         n_err++; $display("FAIL restart_set_order got order_ok %0d restarted %0d exp 1 1", seq_ok, restarted);
      end
   endtask

   task automatic test_reset_mid_work();
      bit found = 1'b0;
      int bad_wr = 0;
      int bad_rdy = 0;
      flush_req = 1'b1;
      cyc();
      flush_req = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         if (u_if.btb_wr_valid === 1'b1 && u_if.btb_wr_op === 2'b10 && u_if.btb_wr_set === 6'd30) found = 1'b1;
         else cyc();
      end
      n_vec++;
      if (!found) begin
         n_err++; $display("FAIL rst_sweep_reach_30 got not_seen exp seen");
      end
      #1 rst = 1'b0;
      #1;
      n_vec++;
      if ({u_if.btb_wr_valid, u_if.btb_wr_op, u_if.btb_wr_set, flush_busy, flush_done, u_if.ex_upd_ready, u_if.id_upd_ready} !== 13'b0000000000011) begin
         n_err++; $display("FAIL rst_sweep_immediate got v %b op %b set %h busy %b done %b rdy %b%b exp zeros rdy11",
                           u_if.btb_wr_valid, u_if.btb_wr_op, u_if.btb_wr_set, flush_busy, flush_done, u_if.ex_upd_ready, u_if.id_upd_ready);
      end
      #6 rst = 1'b1;
      cyc();
      for (int c = 0; c < 70; c++) begin
         @(negedge clk);
         if (u_if.btb_wr_valid !== 1'b0 || flush_done !== 1'b0) bad_wr++;
         if ({u_if.ex_upd_ready, u_if.id_upd_ready} !== 2'b11) bad_rdy++;
         cyc();
      end
      n_vec++;
      if (bad_wr != 0) begin
         n_err++; $display("FAIL rst_sweep_no_write got %0d bad cycles exp 0", bad_wr);
      end
      n_vec++;
      if (bad_rdy != 0) begin
         n_err++; $display("FAIL rst_sweep_ready got %0d bad cycles exp 0", bad_rdy);
      end
      for (int k = 0; k < 2; k++) begin
         drive_ex(1'b1, 1'b0, 32'h1C00_0E00 + 32'(k * 16), 32'h1C00_9000);
         drive_id(1'b1, 1'b0, 32'h1C00_0F00 + 32'(k * 16), 32'h1C00_9100);
         cyc();
      end
      idle_inputs();
      rst = 1'b0;
      #3 rst = 1'b1;
      bad_wr = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (u_if.btb_wr_valid !== 1'b0) bad_wr++;
         cyc();
      end
      n_vec++;
      if (bad_wr != 0) begin
         n_err++; $display("FAIL rst_drain_no_write got %0d bad cycles exp 0", bad_wr);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_single_alloc();
      test_back_to_back();
      test_squash();
      test_flush();
      test_flush_restart();
      test_reset_mid_work();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/btb_upd_ctrl.md
BTB_UPD_CTRL -- requirements
Module: btb_upd_ctrl

Interface
REQ-001 Parameter: DEPTH, 4, update-queue entries; power of two, 2..16.
REQ-002 Parameter: NUM_SETS, 64, predictor sets swept by flush; index width 6.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  in  1  clock.
REQ-005 Port: rst  in  1  asynchronous reset, active-low (0 = reset asserted).
REQ-006 Port: ex_upd_valid  in  1  EXU update request (older instruction).
REQ-007 Port: ex_upd_op  in  1  0 = ALLOC (taken, install target), 1 = INVAL (mispredict, invalidate).
REQ-008 Port: ex_upd_pc / ex_upd_target  in  32 each  branch PC / resolved target.
REQ-009 Port: ex_upd_ready  out  1  EXU request accepted this cycle when high with valid.
REQ-010 Port: id_upd_valid, id_upd_op, id_upd_pc, id_upd_target, id_upd_ready  same widths and meaning as EXU port (younger instruction).
REQ-011 Port: flush_req  in  1  one-cycle request to clear the whole predictor.
REQ-012 Port: flush_busy  out  1  sweep in progress.
REQ-013 Port: flush_done  out  1  one-cycle pulse at sweep completion.
REQ-014 Port: btb_wr_valid  out  1  predictor write strobe, registered.
REQ-015 Port: btb_wr_op  out  2  00 ALLOC, 01 INVAL, 10 CLRSET (clear all ways of one set).
REQ-016 Port: btb_wr_pc / btb_wr_target  out  32 each  write PC / target; 0 for CLRSET.
REQ-017 Port: btb_wr_set  out  6  set index: btb_wr_pc[7:2] for ALLOC/INVAL, sweep counter for CLRSET.

Function
REQ-018 FSM states: IDLE (queue empty), DRAIN (queue non-empty), SWEEP; no other states.
REQ-019 Queue: circular FIFO, DEPTH entries of {live, op, pc, target}; head/tail pointers wrap modulo DEPTH; occupancy counter 0..DEPTH.
REQ-020 ex_upd_ready = (state != SWEEP) && (count < DEPTH); combinational, independent of ex_upd_valid.
REQ-021 id_upd_ready = (state != SWEEP) && (count + (ex_upd_valid ? 1 : 0) < DEPTH); the slot freed by a same-cycle pop is not counted.
REQ-022 Same-cycle enqueue of both ports: EXU entry written at tail, IDU entry at tail+1 (age order preserved).
REQ-023 INVAL enqueue clears live on every older queued, not-yet-popped ALLOC entry with an equal pc; a same-cycle EXU INVAL also squashes a same-cycle IDU ALLOC with equal pc; INVAL entries are never squashed.
REQ-024 Pop: one head entry per cycle whenever count > 0 and state != SWEEP; live entry drives btb_wr_* next cycle with btb_wr_valid = 1; a squashed entry consumes the slot with btb_wr_valid = 0.
REQ-025 Latency: request accepted at cycle N into an empty queue appears on btb_wr_* at cycle N+1; throughput one write per cycle.
REQ-026 Full: count == DEPTH -> both readies low; simultaneous pop and enqueue keep count unchanged; count never exceeds DEPTH or underflows.
REQ-027 flush_req in any state: queue discarded (count = 0, pointers reset), state -> SWEEP, sweep counter = 0, flush_busy = 1 from next cycle.
REQ-028 SWEEP: each cycle issue btb_wr_valid = 1, op CLRSET, btb_wr_set = counter, counter + 1; after set NUM_SETS-1 issued, state -> IDLE, flush_done = 1 for that cycle, flush_busy = 0.
REQ-029 flush_req during SWEEP restarts counter at 0; no flush_done for the aborted sweep.
REQ-030 Requests presented while flush_busy are not accepted (readies low); requesters hold them.
REQ-031 btb_wr_valid is 0 in IDLE and whenever no entry or sweep step issued the previous cycle.

Reset
REQ-032 rst low, asynchronously: state IDLE, count 0, pointers 0, sweep counter 0, all live bits 0.
REQ-033 During reset and the first cycle after: btb_wr_valid 0, btb_wr_op 00, btb_wr_pc/target/set 0, flush_busy 0, flush_done 0, readies 1.
REQ-034 Reset asserted mid-SWEEP or mid-DRAIN abandons all work; no flush_done and no pending write issues after release.

Verification
REQ-035 EX ALLOC pc 0x1C000010 target 0x1C000100, empty queue -> next cycle btb_wr_valid 1, op 00, set 0x04, target 0x1C000100.
REQ-036 DEPTH 4: EX+ID valid 3 cycles, no drain stall -> ordering EX0,ID0,EX1,ID1,...; id_upd_ready low whenever count+1 == 4.
REQ-037 ID ALLOC pc 0x1C000020 queued behind 2 entries, then EX INVAL same pc -> ALLOC slot issues btb_wr_valid 0, INVAL issues op 01 set 0x08.
REQ-038 flush_req with 3 queued entries -> no queued writes issue; 64 CLRSET writes sets 0..63 on consecutive cycles; flush_done on set 63 cycle.
REQ-039 flush_req again at sweep set 20 -> sets restart at 0; exactly one flush_done, 84 CLRSET writes total.
REQ-040 rst low at sweep set 30 -> outputs 0 immediately; after release btb_wr_valid stays 0, readies 1.
